// File: rtl/word_gen_conf_writer.sv
// Word generator configuration writer: serializes a range/char-table snapshot
// into the byte stream the generator's config FSM consumes, ending with 0xBB.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start; inputs validated and snapshotted on start
// NUM_RANGES | presenting the range count byte
// RNG_NCHARS | presenting num_chars of range r
// RNG_START  | presenting start_idx of range r
// CHAR_FETCH | char_addr = {r,c} driven, no byte valid
// CHAR_SEND  | presenting char c of range r (held across stalls)
// GEN0..GEN3 | presenting num_generate bytes, LSB first
// MAGIC      | presenting 0xBB terminator
// ERROR      | bad configuration seen; one cycle, back to IDLE
module word_gen_conf_writer #(
   parameter int CHAR_BITS       = 8,
   parameter int RANGES_MAX      = 8,
   parameter int RANGE_ADDR_BITS = 3,
   parameter int CHAR_ADDR_BITS  = 8
) (
   input  logic                                      CLK,
   input  logic                                      RESET_N,
   input  logic                                      start,
   input  logic [15:0]                               in_pkt_id,
   input  logic [7:0]                                num_ranges,
   input  logic [RANGES_MAX*8-1:0]                   num_chars,
   input  logic [RANGES_MAX*8-1:0]                   start_idx,
   input  logic [31:0]                               num_generate,
   output logic [RANGE_ADDR_BITS+CHAR_ADDR_BITS-1:0] char_addr,
   input  logic [CHAR_BITS-1:0]                      char_data,
   output logic [7:0]                                dout,
   output logic                                      wr_conf_en,
   input  logic                                      conf_full,
   output logic [15:0]                               inpkt_id,
   output logic                                      busy,
   output logic                                      done,
   output logic                                      err
);

   localparam int CHARS_NUMBER_MAX = (CHAR_BITS == 7) ? 127 : 255;
   localparam int AW = RANGE_ADDR_BITS + CHAR_ADDR_BITS;

   typedef enum logic [3:0] {
      S_IDLE, S_NUM_RANGES, S_RNG_NCHARS, S_RNG_START, S_CHAR_FETCH, S_CHAR_SEND,
      S_GEN0, S_GEN1, S_GEN2, S_GEN3, S_MAGIC, S_ERROR
   } state_t;

   state_t                     state_q, state_d;
   logic [7:0]                 dout_q, dout_d;
   logic                       wr_q, wr_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       err_q, err_d;
   logic [AW-1:0]              addr_q, addr_d;
   logic [15:0]                pkt_q, pkt_d;
   logic [7:0]                 nranges_q, nranges_d;
   logic [31:0]                ngen_q, ngen_d;
   logic [7:0]                 nchars_q [RANGES_MAX];
   logic [7:0]                 nchars_d [RANGES_MAX];
   logic [7:0]                 sidx_q [RANGES_MAX];
   logic [7:0]                 sidx_d [RANGES_MAX];
   logic [RANGE_ADDR_BITS-1:0] r_q, r_d, r_inc;
   logic [CHAR_ADDR_BITS-1:0]  c_q, c_d, c_inc;
   logic                       cfg_bad, accept, last_char, last_rng;

   assign accept    = wr_q && !conf_full;
   assign r_inc     = r_q + 1'b1;
   assign c_inc     = c_q + 1'b1;
   assign last_char = int'(c_q) == int'(nchars_q[r_q]) - 1;
   assign last_rng  = int'(r_q) == int'(nranges_q) - 1;

   // Validate the raw inputs so a bad snapshot never starts a stream.
   always_comb begin
      cfg_bad = 1'b0;
      if (int'(num_ranges) > RANGES_MAX) cfg_bad = 1'b1;
      for (int i = 0; i < RANGES_MAX; i++) begin
         if (i < int'(num_ranges)) begin
            if (num_chars[8*i +: 8] == 8'd0 ||
                int'(num_chars[8*i +: 8]) > CHARS_NUMBER_MAX ||
                start_idx[8*i +: 8] >= num_chars[8*i +: 8])
               cfg_bad = 1'b1;
         end
      end
   end

   // Next-state and next-output logic; the following byte is loaded on accept.
   always_comb begin
      state_d   = state_q;
      dout_d    = dout_q;
      wr_d      = wr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      addr_d    = addr_q;
      pkt_d     = pkt_q;
      nranges_d = nranges_q;
      ngen_d    = ngen_q;
      nchars_d  = nchars_q;
      sidx_d    = sidx_q;
      r_d       = r_q;
      c_d       = c_q;
      case (state_q)
         S_IDLE: begin
            // done_q blocks a start landing on the done cycle itself
            if (start && !done_q) begin
               pkt_d     = in_pkt_id;
               nranges_d = num_ranges;
               ngen_d    = num_generate;
               for (int i = 0; i < RANGES_MAX; i++) begin
                  nchars_d[i] = num_chars[8*i +: 8];
                  sidx_d[i]   = start_idx[8*i +: 8];
               end
               r_d = '0;
               c_d = '0;
               if (cfg_bad) begin
                  err_d   = 1'b1;
                  state_d = S_ERROR;
               end else begin
                  busy_d  = 1'b1;
                  wr_d    = 1'b1;
                  dout_d  = num_ranges;
                  state_d = S_NUM_RANGES;
               end
            end
         end
         S_NUM_RANGES: if (accept) begin
            if (nranges_q == 8'd0) begin
               dout_d  = ngen_q[7:0];
               state_d = S_GEN0;
            end else begin
               dout_d  = nchars_q[0];
               state_d = S_RNG_NCHARS;
            end
         end
         S_RNG_NCHARS: if (accept) begin
            dout_d  = sidx_q[r_q];
            state_d = S_RNG_START;
         end
         S_RNG_START: if (accept) begin
            wr_d    = 1'b0;
            c_d     = '0;
            addr_d  = {r_q, {CHAR_ADDR_BITS{1'b0}}};
            state_d = S_CHAR_FETCH;
         end
         S_CHAR_FETCH: begin
            dout_d  = 8'(char_data);
            wr_d    = 1'b1;
            state_d = S_CHAR_SEND;
         end
         S_CHAR_SEND: if (accept) begin
            if (last_char) begin
               if (last_rng) begin
                  dout_d  = ngen_q[7:0];
                  state_d = S_GEN0;
               end else begin
                  r_d     = r_inc;
                  dout_d  = nchars_q[r_inc];
                  state_d = S_RNG_NCHARS;
               end
            end else begin
               c_d     = c_inc;
               addr_d  = {r_q, c_inc};
               wr_d    = 1'b0;
               state_d = S_CHAR_FETCH;
            end
         end
         S_GEN0: if (accept) begin dout_d = ngen_q[15:8];  state_d = S_GEN1; end
         S_GEN1: if (accept) begin dout_d = ngen_q[23:16]; state_d = S_GEN2; end
         S_GEN2: if (accept) begin dout_d = ngen_q[31:24]; state_d = S_GEN3; end
         S_GEN3: if (accept) begin dout_d = 8'hBB;         state_d = S_MAGIC; end
         S_MAGIC: if (accept) begin
            wr_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            dout_d  = 8'h00;
            state_d = S_IDLE;
         end
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         dout_q    <= '0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         pkt_q     <= '0;
         nranges_q <= '0;
         ngen_q    <= '0;
         r_q       <= '0;
         c_q       <= '0;
         for (int i = 0; i < RANGES_MAX; i++) begin
            nchars_q[i] <= '0;
            sidx_q[i]   <= '0;
         end
      end else begin
         state_q   <= state_d;
         dout_q    <= dout_d;
         wr_q      <= wr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         pkt_q     <= pkt_d;
         nranges_q <= nranges_d;
         ngen_q    <= ngen_d;
         r_q       <= r_d;
         c_q       <= c_d;
         nchars_q  <= nchars_d;
         sidx_q    <= sidx_d;
      end
   end

   assign char_addr  = addr_q;
   assign dout       = dout_q;
   assign wr_conf_en = wr_q;
   assign inpkt_id   = pkt_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: doc/word_gen_conf_writer.md
Name: word_gen_conf_writer

Overview:
- Transmitter for the word generator configuration byte stream; drives the generator's `din`, `wr_conf_en`, `inpkt_id` and observes its `conf_full`.
- Takes a parallel configuration snapshot (range descriptors, generation limit) plus a character table held in external RAM.
- Serializes it in the exact byte order the generator's config FSM expects, ending with magic 0xBB.
- Sits between the host-side packet parser and the word generator, so configuration can be built from a decoded packet or a local test source.

Parameters:
- CHAR_BITS, 8, char width (7 or 8); CHARS_NUMBER_MAX = 127 if 7, else 255.
- RANGES_MAX, 8, max number of ranges; must match the generator.
- RANGE_ADDR_BITS, 3, width of range index in char_addr, = MSB(RANGES_MAX-1)+1.
- CHAR_ADDR_BITS, 8, width of char index in char_addr.

Ports:
- CLK  in  1  single clock.
- RESET_N  in  1  synchronous, active-low reset.
- start  in  1  pulse; latch inputs and begin a transfer (ignored unless idle).
- in_pkt_id  in  16  packet ID latched at start.
- num_ranges  in  8  number of ranges, 0..RANGES_MAX.
- num_chars  in  RANGES_MAX*8  per-range char count, range i at [8i+7:8i].
- start_idx  in  RANGES_MAX*8  per-range start index, same packing.
- num_generate  in  32  generation limit, 0 = unlimited.
- char_addr  out  RANGE_ADDR_BITS+CHAR_ADDR_BITS  {range, index} read address into the char RAM.
- char_data  in  CHAR_BITS  RAM read data, valid exactly 1 cycle after char_addr is presented.
- dout  out  8  config byte to the generator `din`; upper bits are 0 when CHAR_BITS=7.
- wr_conf_en  out  1  byte valid.
- conf_full  in  1  generator back-pressure.
- inpkt_id  out  16  latched in_pkt_id, stable for the whole transfer.
- busy  out  1  transfer in progress.
- done  out  1  1-cycle pulse after the magic byte is accepted.
- err  out  1  sticky config error; cleared only by reset.

Behaviour:
- Reset (RESET_N=0 at posedge): state IDLE; dout=0, wr_conf_en=0, busy=0, done=0, err=0, char_addr=0, inpkt_id=0. Reset mid-transfer aborts immediately and no further bytes are driven.
- Handshake: a byte is accepted on a cycle with wr_conf_en=1 and conf_full=0. While wr_conf_en=1 and the byte is not accepted, dout stays stable. Outputs are registered.
- Start: in IDLE with start=1, snapshot all inputs and set busy=1. Validation is done in the same cycle on the raw inputs. Error if any of:
  - num_ranges > RANGES_MAX;
  - for any range i < num_ranges: num_chars[i]==0, num_chars[i] > CHARS_NUMBER_MAX, or start_idx[i] >= num_chars[i].
- On error: go to ERROR, err=1, busy stays 0, no bytes emitted; return to IDLE the next cycle. err remains set.
- start while busy is ignored.
- Byte order:
  - num_ranges.
  - For each range r = 0..num_ranges-1: num_chars[r], start_idx[r], then chars 0..num_chars[r]-1.
  - num_generate[7:0], [15:8], [23:16], [31:24].
  - 0xBB.
- States: IDLE, NUM_RANGES, RNG_NCHARS, RNG_START, CHAR_FETCH, CHAR_SEND, GEN0, GEN1, GEN2, GEN3, MAGIC, ERROR.
  - Non-char states emit one byte; the next byte is loaded on the accept cycle, so throughput is 1 byte/cycle when conf_full=0.
  - CHAR_FETCH drives char_addr={r,c} with wr_conf_en=0.
  - CHAR_SEND presents char_data (registered into dout) with wr_conf_en=1. Throughput for chars is 1 byte per 2 cycles.
  - On accept of the last char (c==num_chars[r]-1): if r==num_ranges-1 go to GEN0, else r+1 and go to RNG_NCHARS. c and r are counters and are never wrapped beyond their limits.
- num_ranges==0: after NUM_RANGES, go directly to GEN0.
- Latency: first wr_conf_en=1 occurs 1 cycle after the start cycle.
- On MAGIC accept: wr_conf_en=0, busy=0, done=1 for 1 cycle, go to IDLE.
- A new start is accepted on the cycle after done. The generator holds conf_full=1 until its operation ends, which naturally stalls the next transfer's first byte.
- conf_full asserted at any point stalls without byte loss or duplication. A stall in CHAR_SEND holds dout; the RAM is not re-read.

Test Plan:
- Passthrough config: num_ranges=0, num_generate=0, conf_full=0 -> bytes 00,00,00,00,00,BB on 6 consecutive cycles; done pulses 1 cycle after BB; inpkt_id = in_pkt_id.
- 2 ranges: (3 chars "abc", start 1) and (1 char "z", start 0), num_generate=0x01020304 -> stream 02,03,01,61,62,63,01,00,7A,04,03,02,01,BB; char_addr sequence {0,0},{0,1},{0,2},{1,0}.
- Random conf_full toggling (50%) on the 2-range case -> identical byte sequence, each byte accepted exactly once, dout stable during every stall.
- Errors: num_ranges=RANGES_MAX+1; num_chars[0]=0; start_idx[0]=3 with num_chars[0]=3 -> err=1, no wr_conf_en ever asserted, busy=0.
- RESET_N=0 mid-range-chars, then re-run the passthrough config -> outputs at reset values; clean 6-byte stream afterwards.
- start during busy, and start on the done cycle -> first ignored; start one cycle after done begins a new transfer.
